// File: rtl/stage_mem_pkg.sv
// Shared pipeline parameters for the memory stage: write-source select
// encodings and the data-memory access FSM state encoding.
`timescale 1ns/1ps
package stage_mem_pkg;

  // Register-file write-source select values; anything else behaves as ALU.
  localparam int unsigned RF_SRC_ALU = 0;
  localparam int unsigned RF_SRC_MEM = 1;

  // Data-memory access FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/stage_mem_mem_access_fsm.sv
// Data-memory handshake FSM: issues exactly one request per memory op held
// in the stage register, stalls until dmem_ready, and latches the read data.
`timescale 1ns/1ps
module mem_access_fsm
  import stage_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_i,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        dmem_req_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_q_o
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  // Next state, request/stall/done outputs and read-data capture.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d    = state_q;
    rdata_d    = rdata_q;
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_op_i) begin
          dmem_req_o = 1'b1;
          if (dmem_ready_i) begin
            // Zero-wait access: completes in the capture cycle, no stall.
            done_o  = 1'b1;
            rdata_d = dmem_rdata_i;
          end else begin
            stall_o = 1'b1;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // Stage register is frozen here, so address/we/wdata stay stable.
        dmem_req_o = 1'b1;
        if (dmem_ready_i) begin
          done_o  = 1'b1;
          rdata_d = dmem_rdata_i;
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      // The DONE behaviour is folded into the ready cycle and never held.
      default: state_d = ST_IDLE;
    endcase
  end

  // State and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_q_o = rdata_q;

endmodule

// File: rtl/stage_mem.sv
// Pipeline memory stage: registers the EX results, drives the data-memory
// port through mem_access_fsm and selects the writeback value.
`timescale 1ns/1ps
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int RF_SRC_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ex_opResult,
  input  logic                ex_memWE,
  input  logic [31:0]         ex_memData,
  input  logic                ex_rfWE,
  input  logic [4:0]          ex_rfDst,
  input  logic [RF_SRC_W-1:0] ex_rfSrc,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ready,
  input  logic [31:0]         dmem_rdata,
  output logic                mem_rfWE,
  output logic [4:0]          mem_rfDst,
  output logic [31:0]         mem_rfWData,
  output logic                mem_stall
);

  typedef struct packed {
    logic [31:0]         op_result;
    logic                mem_we;
    logic [31:0]         mem_data;
    logic                rf_we;
    logic [4:0]          rf_dst;
    logic [RF_SRC_W-1:0] rf_src;
  } ex_op_t;

  ex_op_t      op_q, op_d;
  logic        is_store, is_load, mem_op;
  logic        access_done, op_complete;
  logic [31:0] rdata_q;

  // Capture a new EX op unless the stage is stalled on memory.
  always_comb begin
    op_d = op_q;
    if (!mem_stall) begin
      op_d = '{op_result: ex_opResult, mem_we: ex_memWE, mem_data: ex_memData,
               rf_we: ex_rfWE, rf_dst: ex_rfDst, rf_src: ex_rfSrc};
    end
  end

  // Stage register; reset leaves a plain op with no writeback.
  always_ff @(posedge clk) begin
    if (rst) op_q <= '0;
    else     op_q <= op_d;
  end

  assign is_store = op_q.mem_we;
  assign is_load  = !op_q.mem_we && (op_q.rf_src == RF_SRC_W'(RF_SRC_MEM));
  assign mem_op   = is_store || is_load;

  mem_access_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_op_i     (mem_op),
    .dmem_ready_i (dmem_ready),
    .dmem_rdata_i (dmem_rdata),
    .dmem_req_o   (dmem_req),
    .stall_o      (mem_stall),
    .done_o       (access_done),
    .rdata_q_o    (rdata_q)
  );

  // Word-aligned address; we/wdata mirror the registered op.
  assign dmem_addr  = {op_q.op_result[31:2], 2'b00};
  assign dmem_we    = op_q.mem_we;
  assign dmem_wdata = op_q.mem_data;

  // Plain ops complete in their capture cycle, memory ops on the ready cycle.
  assign op_complete = mem_op ? access_done : 1'b1;

  assign mem_rfDst   = op_q.rf_dst;
  assign mem_rfWE    = op_q.rf_we && !is_store && (op_q.rf_dst != 5'd0) && op_complete;
  assign mem_rfWData = is_load ? (access_done ? dmem_rdata : rdata_q) : op_q.op_result;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: ops are issued like an upstream stage,
// a memory responder answers requests, and a monitor checks every accepted
// request and every writeback against a transaction-level model.
`timescale 1ns/1ps
module tb_stage_mem;
  import stage_mem_pkg::*;

  localparam int RF_SRC_W = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [31:0]         ex_opResult, ex_memData;
  logic                ex_memWE, ex_rfWE;
  logic [4:0]          ex_rfDst;
  logic [RF_SRC_W-1:0] ex_rfSrc;
  logic                dmem_req, dmem_we, dmem_ready;
  logic [31:0]         dmem_addr, dmem_wdata, dmem_rdata;
  logic                mem_rfWE, mem_stall;
  logic [4:0]          mem_rfDst;
  logic [31:0]         mem_rfWData;

  stage_mem #(.RF_SRC_W(RF_SRC_W)) dut (
    .clk(clk), .rst(rst),
    .ex_opResult(ex_opResult), .ex_memWE(ex_memWE), .ex_memData(ex_memData),
    .ex_rfWE(ex_rfWE), .ex_rfDst(ex_rfDst), .ex_rfSrc(ex_rfSrc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_rfWE(mem_rfWE), .mem_rfDst(mem_rfDst), .mem_rfWData(mem_rfWData),
    .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct packed { logic [4:0] dst; logic [31:0] data; } wb_t;

  req_t        exp_req[$];
  wb_t         exp_wb[$];
  int          wait_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] env_mem[logic [31:0]];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Contents of a never-written memory word.
  function automatic logic [31:0] init_word(input logic [31:0] widx);
    return (widx * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] w;
    w = addr >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // Memory responder: random or queued wait count per fresh request;
  // ready pulses while no request is pending are noise the DUT must ignore.
  initial begin
    int left;
    logic [31:0] w;
    left = -1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dmem_ready) left = -1;
      if (rst) begin
        dmem_ready = 1'b0;
        left = -1;
      end else if (!dmem_req) begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        left = -1;
      end else begin
        if (left < 0) left = (wait_q.size() != 0) ? wait_q.pop_front() : int'($urandom_range(0, 3));
        if (left == 0) begin
          dmem_ready = 1'b1;
          w = dmem_addr >> 2;
          if (dmem_we) begin
            env_mem[w] = dmem_wdata;
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = env_mem.exists(w) ? env_mem[w] : init_word(w);
          end
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = $urandom;
          left--;
        end
      end
    end
  end

  // Monitor: pops and compares on every accepted request and every writeback.
  initial begin
    req_t er;
    wb_t  ew;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dmem_req && dmem_ready) begin
          if (exp_req.size() == 0) begin
            check(1'b0, "unexpected dmem request", {31'd0, dmem_we, dmem_addr}, 64'd0);
          end else begin
            er = exp_req.pop_front();
            check(dmem_we == er.we, "dmem_we", 64'(dmem_we), 64'(er.we));
            check(dmem_addr == er.addr, "dmem_addr", 64'(dmem_addr), 64'(er.addr));
            check(dmem_wdata == er.wdata, "dmem_wdata", 64'(dmem_wdata), 64'(er.wdata));
          end
        end
        if (mem_rfWE) begin
          if (exp_wb.size() == 0) begin
            check(1'b0, "unexpected writeback", {27'd0, mem_rfDst, mem_rfWData}, 64'd0);
          end else begin
            ew = exp_wb.pop_front();
            check(mem_rfDst == ew.dst, "mem_rfDst", 64'(mem_rfDst), 64'(ew.dst));
            check(mem_rfWData == ew.data, "mem_rfWData", 64'(mem_rfWData), 64'(ew.data));
          end
        end
      end
    end
  end

  task automatic bubble();
    ex_opResult = '0; ex_memWE = 1'b0; ex_memData = '0;
    ex_rfWE = 1'b0; ex_rfDst = '0; ex_rfSrc = '0;
  endtask

  // Present one op, hold it through stalls, record its expected effects at
  // the capture edge, then leave a harmless bubble on the inputs.
  task automatic issue(input logic we, input logic [31:0] res, input logic [31:0] data,
                       input logic rfwe, input logic [4:0] dst, input logic [1:0] src);
    int  n;
    bit  st, ld;
    ex_opResult = res; ex_memWE = we; ex_memData = data;
    ex_rfWE = rfwe; ex_rfDst = dst; ex_rfSrc = src;
    n = 0;
    @(negedge clk);
    while (mem_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    check(n < 50, "accept timeout", 64'(n), 64'd50);
    @(posedge clk);
    st = we;
    ld = !we && (src == 2'(RF_SRC_MEM));
    if (st || ld) exp_req.push_back('{we: we, addr: res & 32'hFFFF_FFFC, wdata: data});
    if (!st && rfwe && dst != 5'd0)
      exp_wb.push_back('{dst: dst, data: ld ? ref_read(res) : res});
    if (st) ref_mem[res >> 2] = data;
    #1;
    bubble();
  endtask

  initial begin
    int stalls, wbs, wes, k;
    logic        r_we, r_wb;
    logic [1:0]  r_src;
    logic [31:0] r_res;

    ref_mem[32'h40] = 32'hDEAD_BEEF;
    env_mem[32'h40] = 32'hDEAD_BEEF;

    // Reset held two cycles with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ex_opResult = $urandom; ex_memWE = 1'($urandom); ex_memData = $urandom;
      ex_rfWE = 1'($urandom); ex_rfDst = 5'($urandom); ex_rfSrc = 2'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check(dmem_req == 1'b0, "reset dmem_req", 64'(dmem_req), 64'd0);
    check(dmem_we == 1'b0, "reset dmem_we", 64'(dmem_we), 64'd0);
    check(dmem_addr == 32'd0, "reset dmem_addr", 64'(dmem_addr), 64'd0);
    check(dmem_wdata == 32'd0, "reset dmem_wdata", 64'(dmem_wdata), 64'd0);
    check(mem_rfWE == 1'b0, "reset mem_rfWE", 64'(mem_rfWE), 64'd0);
    check(mem_rfDst == 5'd0, "reset mem_rfDst", 64'(mem_rfDst), 64'd0);
    check(mem_rfWData == 32'd0, "reset mem_rfWData", 64'(mem_rfWData), 64'd0);
    check(mem_stall == 1'b0, "reset mem_stall", 64'(mem_stall), 64'd0);
    rst = 1'b0;
    bubble();
    @(posedge clk); #1;

    // Plain ALU op writes back the cycle after EX.
    issue(1'b0, 32'h1234, 32'h0, 1'b1, 5'd5, 2'(RF_SRC_ALU));
    @(negedge clk);
    check(mem_rfWE == 1'b1, "alu mem_rfWE", 64'(mem_rfWE), 64'd1);
    check(mem_rfDst == 5'd5, "alu mem_rfDst", 64'(mem_rfDst), 64'd5);
    check(mem_rfWData == 32'h1234, "alu mem_rfWData", 64'(mem_rfWData), 64'h1234);
    check(dmem_req == 1'b0, "alu dmem_req", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;

    // Load with three wait cycles from a misaligned address.
    wait_q.push_back(3);
    issue(1'b0, 32'h103, 32'h0, 1'b1, 5'd7, 2'(RF_SRC_MEM));
    stalls = 0; wbs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check(dmem_addr == 32'h100, "load dmem_addr", 64'(dmem_addr), 64'h100);
      if (mem_stall) stalls++;
      if (mem_rfWE) begin
        wbs++;
        check(mem_rfWData == 32'hDEAD_BEEF, "load data", 64'(mem_rfWData), 64'hDEAD_BEEF);
      end
    end
    check(stalls == 3, "load stall cycles", 64'(stalls), 64'd3);
    check(wbs == 1, "load writeback count", 64'(wbs), 64'd1);
    @(posedge clk); #1;

    // Zero-wait store: one write cycle, no stall, no writeback.
    wait_q.push_back(0);
    issue(1'b1, 32'h40, 32'hA5A5_A5A5, 1'b1, 5'd3, 2'(RF_SRC_ALU));
    stalls = 0; wbs = 0; wes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      if (mem_rfWE) wbs++;
      if (dmem_we) wes++;
    end
    check(wes == 1, "store dmem_we cycles", 64'(wes), 64'd1);
    check(stalls == 0, "store stall cycles", 64'(stalls), 64'd0);
    check(wbs == 0, "store writeback count", 64'(wbs), 64'd0);
    @(posedge clk); #1;

    // Reset one wait cycle into an access abandons it.
    wait_q.push_back(5);
    issue(1'b0, 32'h200, 32'h0, 1'b1, 5'd9, 2'(RF_SRC_MEM));
    @(negedge clk);
    @(negedge clk);
    check(mem_stall == 1'b1, "access stall", 64'(mem_stall), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check(dmem_req == 1'b0, "abandon dmem_req", 64'(dmem_req), 64'd0);
    check(mem_rfWE == 1'b0, "abandon mem_rfWE", 64'(mem_rfWE), 64'd0);
    rst = 1'b0;
    exp_req.delete();
    exp_wb.delete();
    wait_q.delete();
    wbs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_rfWE || dmem_req) wbs++;
    end
    check(wbs == 0, "abandon activity", 64'(wbs), 64'd0);
    @(posedge clk); #1;

    // Back-to-back load then store, one wait cycle each.
    wait_q.push_back(1);
    wait_q.push_back(1);
    issue(1'b0, 32'h300, 32'h0, 1'b1, 5'd10, 2'(RF_SRC_MEM));
    issue(1'b1, 32'h304, 32'h0BAD_F00D, 1'b0, 5'd0, 2'(RF_SRC_ALU));

    // Randomised traffic, including reserved write-source codes and x0.
    for (int i = 0; i < 300; i++) begin
      r_we  = ($urandom_range(0, 3) == 0);
      r_src = 2'($urandom);
      r_res = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'h3F);
      r_wb  = 1'($urandom);
      issue(r_we, r_res, $urandom, r_wb, 5'($urandom), r_src);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    k = 0;
    while ((exp_req.size() != 0 || exp_wb.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(exp_req.size() == 0, "pending requests", 64'(exp_req.size()), 64'd0);
    check(exp_wb.size() == 0, "pending writebacks", 64'(exp_wb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
